// File: rtl/id_ex_reg_if.sv
// Decode-to-execute pipeline bus: decode operands/controls, write-back bypass
// source, pipeline steering and the registered execute-stage view.
interface id_ex_reg_if;
  logic        id_valid;
  logic [31:0] id_pc4, id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst;
  logic [3:0]  id_alu_op;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_hold, flush;
  logic        ex_valid;
  logic [31:0] ex_pc4, ex_rs_data, ex_rt_data, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst;
  logic [3:0]  ex_alu_op;
  logic        stall_id;
  logic [15:0] bubble_count;

  modport master (
    output id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
           id_alu_op, wb_reg_write, wb_rd, wb_data, ex_hold, flush,
    input  ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst,
           ex_alu_op, stall_id, bubble_count
  );

  modport slave (
    input  id_valid, id_pc4, id_rs_data, id_rt_data, id_imm, id_rs, id_rt, id_rd, id_uses_rt,
           id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
           id_alu_op, wb_reg_write, wb_rd, wb_data, ex_hold, flush,
    output ex_valid, ex_pc4, ex_rs_data, ex_rt_data, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst,
           ex_alu_op, stall_id, bubble_count
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, write-back bypass
// of register-file read data, and a saturating bubble counter.
module id_ex_reg (
  input logic         clk,
  input logic         rst,
  id_ex_reg_if.slave  bus
);
  typedef struct packed {
    logic        valid;
    logic [31:0] pc4, rsData, rtData, imm;
    logic [4:0]  rs, rt, rd;
    logic        regWrite, memRead, memWrite, memToReg, aluSrc, regDst;
    logic [3:0]  aluOp;
  } exPayload_t;

  exPayload_t  exQ, exD;
  logic [15:0] bubbleCnt;
  logic        loadUse, squash, rsHit, rtHit;

  // $0 is hardwired zero, so it can neither create a hazard nor be bypassed.
  assign loadUse = exQ.valid & exQ.memRead & bus.id_valid & (exQ.rt != 5'd0) &
                   ((exQ.rt == bus.id_rs) | (bus.id_uses_rt & (exQ.rt == bus.id_rt)));
  assign squash  = bus.flush | loadUse;
  assign rsHit   = bus.wb_reg_write & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rs);
  assign rtHit   = bus.wb_reg_write & (bus.wb_rd != 5'd0) & (bus.wb_rd == bus.id_rt);

  assign bus.stall_id = bus.ex_hold | (loadUse & ~bus.flush);

  always_comb begin
    exD = '0;
    if (!squash && bus.id_valid) begin
      exD.valid    = 1'b1;
      exD.pc4      = bus.id_pc4;
      exD.rsData   = rsHit ? bus.wb_data : bus.id_rs_data;
      exD.rtData   = rtHit ? bus.wb_data : bus.id_rt_data;
      exD.imm      = bus.id_imm;
      exD.rs       = bus.id_rs;
      exD.rt       = bus.id_rt;
      exD.rd       = bus.id_rd;
      exD.regWrite = bus.id_reg_write;
      exD.memRead  = bus.id_mem_read;
      exD.memWrite = bus.id_mem_write;
      exD.memToReg = bus.id_mem_to_reg;
      exD.aluSrc   = bus.id_alu_src;
      exD.regDst   = bus.id_reg_dst;
      exD.aluOp    = bus.id_alu_op;
    end
  end

  // Only hazard/flush bubbles are counted; idle decode slots are not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exQ       <= '0;
      bubbleCnt <= '0;
    end else if (!bus.ex_hold) begin
      exQ <= exD;
      if (squash && bubbleCnt != 16'hFFFF) bubbleCnt <= bubbleCnt + 16'd1;
    end
  end

  assign bus.ex_valid      = exQ.valid;
  assign bus.ex_pc4        = exQ.pc4;
  assign bus.ex_rs_data    = exQ.rsData;
  assign bus.ex_rt_data    = exQ.rtData;
  assign bus.ex_imm        = exQ.imm;
  assign bus.ex_rs         = exQ.rs;
  assign bus.ex_rt         = exQ.rt;
  assign bus.ex_rd         = exQ.rd;
  assign bus.ex_reg_write  = exQ.regWrite;
  assign bus.ex_mem_read   = exQ.memRead;
  assign bus.ex_mem_write  = exQ.memWrite;
  assign bus.ex_mem_to_reg = exQ.memToReg;
  assign bus.ex_alu_src    = exQ.aluSrc;
  assign bus.ex_reg_dst    = exQ.regDst;
  assign bus.ex_alu_op     = exQ.aluOp;
  assign bus.bubble_count  = bubbleCnt;
endmodule

// File: tb/tb_id_ex_reg.sv
// Randomized + directed bench for id_ex_reg against an instruction-level model.
module tb_id_ex_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_ex_reg_if ifc ();
  id_ex_reg dut (.clk(clk), .rst(rst), .bus(ifc));

  typedef struct {
    logic        valid;
    logic [31:0] pc4, rsd, rtd, imm;
    logic [4:0]  rs, rt, rd;
    logic        rw, mr, mw, m2r, as, rdst;
    logic [3:0]  op;
  } mdl_t;

  mdl_t m, mNext;
  int   mCnt, cntNext;
  int   nChecks = 0;
  int   nErrs   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrs++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic mdl_t zeroMdl();
    mdl_t z;
    z.valid = 0; z.pc4 = 0; z.rsd = 0; z.rtd = 0; z.imm = 0;
    z.rs = 0; z.rt = 0; z.rd = 0;
    z.rw = 0; z.mr = 0; z.mw = 0; z.m2r = 0; z.as = 0; z.rdst = 0; z.op = 0;
    return z;
  endfunction

  // Decode instruction depends on a load currently in EX.
  function automatic bit hazard();
    if (!(m.valid && m.mr && ifc.id_valid) || m.rt == 0) return 0;
    return (m.rt == ifc.id_rs) || (ifc.id_uses_rt && m.rt == ifc.id_rt);
  endfunction

  function automatic logic [31:0] readOperand(input logic [4:0] r, input logic [31:0] rf);
    if (ifc.wb_reg_write && ifc.wb_rd != 0 && ifc.wb_rd == r) return ifc.wb_data;
    return rf;
  endfunction

  task automatic predict();
    mNext = m; cntNext = mCnt;
    if (ifc.ex_hold) return;
    if (ifc.flush || hazard()) begin
      mNext = zeroMdl();
      if (mCnt < 65535) cntNext = mCnt + 1;
    end else if (!ifc.id_valid) mNext = zeroMdl();
    else begin
      mNext.valid = 1; mNext.pc4 = ifc.id_pc4; mNext.imm = ifc.id_imm;
      mNext.rsd = readOperand(ifc.id_rs, ifc.id_rs_data);
      mNext.rtd = readOperand(ifc.id_rt, ifc.id_rt_data);
      mNext.rs = ifc.id_rs; mNext.rt = ifc.id_rt; mNext.rd = ifc.id_rd;
      mNext.rw = ifc.id_reg_write; mNext.mr = ifc.id_mem_read; mNext.mw = ifc.id_mem_write;
      mNext.m2r = ifc.id_mem_to_reg; mNext.as = ifc.id_alu_src; mNext.rdst = ifc.id_reg_dst;
      mNext.op = ifc.id_alu_op;
    end
  endtask

  task automatic checkOuts();
    chk("ex_valid", 32'(ifc.ex_valid), 32'(m.valid));
    chk("ex_pc4", ifc.ex_pc4, m.pc4);
    chk("ex_rs_data", ifc.ex_rs_data, m.rsd);
    chk("ex_rt_data", ifc.ex_rt_data, m.rtd);
    chk("ex_imm", ifc.ex_imm, m.imm);
    chk("ex_rs", 32'(ifc.ex_rs), 32'(m.rs));
    chk("ex_rt", 32'(ifc.ex_rt), 32'(m.rt));
    chk("ex_rd", 32'(ifc.ex_rd), 32'(m.rd));
    chk("ex_ctl", 32'({ifc.ex_reg_write, ifc.ex_mem_read, ifc.ex_mem_write,
                       ifc.ex_mem_to_reg, ifc.ex_alu_src, ifc.ex_reg_dst}),
                  32'({m.rw, m.mr, m.mw, m.m2r, m.as, m.rdst}));
    chk("ex_alu_op", 32'(ifc.ex_alu_op), 32'(m.op));
    chk("bubble_count", 32'(ifc.bubble_count), 32'(mCnt));
  endtask

  // Inputs are settled before this is called (just after a falling edge).
  task automatic tick(input bit doChk);
    #1;
    if (doChk) chk("stall_id", 32'(ifc.stall_id), 32'(ifc.ex_hold | (hazard() & ~ifc.flush)));
    predict();
    @(posedge clk);
    m = mNext; mCnt = cntNext;
    #1;
    if (doChk) checkOuts();
    @(negedge clk);
  endtask

  task automatic randInputs(input bit bursty);
    ifc.id_valid = ($urandom_range(7) != 0);
    ifc.id_pc4 = $urandom; ifc.id_rs_data = $urandom; ifc.id_rt_data = $urandom;
    ifc.id_imm = $urandom;
    ifc.id_rs = 5'($urandom_range(7)); ifc.id_rt = 5'($urandom_range(7));
    ifc.id_rd = 5'($urandom);
    ifc.id_uses_rt = 1'($urandom); ifc.id_reg_write = 1'($urandom);
    ifc.id_mem_read = ($urandom_range(2) == 0); ifc.id_mem_write = 1'($urandom);
    ifc.id_mem_to_reg = 1'($urandom); ifc.id_alu_src = 1'($urandom);
    ifc.id_reg_dst = 1'($urandom); ifc.id_alu_op = 4'($urandom);
    ifc.wb_reg_write = 1'($urandom); ifc.wb_rd = 5'($urandom_range(7));
    ifc.wb_data = $urandom;
    ifc.ex_hold = bursty && ($urandom_range(5) == 0);
    ifc.flush   = bursty && ($urandom_range(7) == 0);
  endtask

  task automatic quiet();
    randInputs(0);
    ifc.id_valid = 0; ifc.id_mem_read = 0; ifc.wb_reg_write = 0;
    ifc.id_uses_rt = 0; ifc.id_rs = 0; ifc.id_rt = 0;
  endtask

  task automatic resetCheck();
    chk("rst_valid", 32'(ifc.ex_valid), 32'd0);
    chk("rst_stall", 32'(ifc.stall_id), 32'd0);
    chk("rst_data", ifc.ex_pc4 | ifc.ex_rs_data | ifc.ex_rt_data | ifc.ex_imm, 32'd0);
    chk("rst_ctl", 32'({ifc.ex_reg_write, ifc.ex_mem_read, ifc.ex_mem_write, ifc.ex_mem_to_reg,
                        ifc.ex_alu_src, ifc.ex_reg_dst, ifc.ex_alu_op, ifc.ex_rs, ifc.ex_rt,
                        ifc.ex_rd}), 32'd0);
    chk("rst_count", 32'(ifc.bubble_count), 32'd0);
  endtask

  // Put a load with the given rt into EX, then present a dependent-candidate instruction.
  task automatic loadThen(input logic [4:0] ldRt, input logic [4:0] rs, input logic [4:0] rt,
                          input bit usesRt, input bit expStall);
    quiet(); ifc.id_valid = 1; ifc.id_mem_read = 1; ifc.id_rt = ldRt; ifc.id_rs = 5'd9;
    tick(1);
    quiet(); ifc.id_valid = 1; ifc.id_rs = rs; ifc.id_rt = rt; ifc.id_uses_rt = usesRt;
    ifc.id_reg_write = 1;
    #1 chk("lu_stall", 32'(ifc.stall_id), 32'(expStall));
    tick(1);
    if (expStall) begin
      chk("lu_bubble", 32'({ifc.ex_valid, ifc.ex_reg_write}), 32'd0);
      #1 chk("lu_stall_drop", 32'(ifc.stall_id), 32'd0);
      tick(1);
    end
    chk("lu_adv", 32'({ifc.ex_valid, ifc.ex_rs}), 32'({1'b1, rs}));
  endtask

  initial begin
    int base;
    m = zeroMdl(); mCnt = 0;
    randInputs(0); ifc.ex_hold = 0; ifc.flush = 0;
    #3 resetCheck();
    @(negedge clk); rst = 1;

    quiet(); ifc.id_valid = 1; ifc.id_imm = 32'h0000_FFFF;
    tick(1);
    chk("first_imm", ifc.ex_imm, 32'h0000_FFFF);
    chk("first_valid", 32'(ifc.ex_valid), 32'd1);

    base = mCnt;
    loadThen(5'd5, 5'd5, 5'd1, 0, 1);
    chk("lu_count", 32'(ifc.bubble_count), 32'(base + 1));
    loadThen(5'd0, 5'd0, 5'd0, 1, 0);
    loadThen(5'd7, 5'd2, 5'd7, 0, 0);
    loadThen(5'd7, 5'd2, 5'd7, 1, 1);

    quiet(); ifc.id_valid = 1; ifc.id_rs = 3; ifc.id_rs_data = 0;
    ifc.wb_reg_write = 1; ifc.wb_rd = 3; ifc.wb_data = 32'hDEAD_BEEF;
    tick(1);
    chk("byp_hit", ifc.ex_rs_data, 32'hDEAD_BEEF);
    ifc.id_rs = 0; ifc.wb_rd = 0;
    tick(1);
    chk("byp_r0", ifc.ex_rs_data, 32'h0);

    base = mCnt;
    quiet(); ifc.id_valid = 1; ifc.flush = 1;
    tick(1);
    chk("flush_count", 32'(ifc.bubble_count), 32'(base + 1));
    quiet(); ifc.id_valid = 1; ifc.id_pc4 = 32'h1234;
    tick(1);
    ifc.flush = 1; ifc.ex_hold = 1; ifc.id_pc4 = 32'h5678;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("hold_pc4", ifc.ex_pc4, 32'h1234);
      chk("hold_stall", 32'(ifc.stall_id), 32'd1);
    end
    ifc.ex_hold = 0;
    tick(1);
    chk("unhold_bubble", 32'(ifc.ex_valid), 32'd0);
    chk("unhold_count", 32'(ifc.bubble_count), 32'(base + 2));

    for (int i = 0; i < 3000; i++) begin
      randInputs(1);
      if (i == 1500) begin
        #2 rst = 0;
        m = zeroMdl(); mCnt = 0;
        #1 resetCheck();
        @(negedge clk); rst = 1;
      end
      tick(1);
    end

    quiet(); ifc.flush = 1;
    for (int i = 0; i < 65540; i++) tick(i >= 65530);
    chk("sat_count", 32'(ifc.bubble_count), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", nChecks, nErrs);
    $finish;
  end
endmodule
